// File: rtl/vj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vj_pkg
// Description : Shared state encoding and frame-format constants for the
//               virtual JTAG UART receive parser and transmit FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package vj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } vj_state_e;

  localparam logic [7:0] VJ_SOF             = 8'h7E;
  localparam int         VJ_MAX_LEN_DEFAULT = 16;
  localparam int         VJ_TIMEOUT_DEFAULT = 1000;
  localparam logic [7:0] VJ_LEN_MIN         = 8'd1;
  // LEN + payload + CSUM must wrap to this value for a frame to verify.
  localparam logic [7:0] VJ_CSUM_GOOD       = 8'h00;

  function automatic logic [7:0] vj_csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vj_rx_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : vj_rx_parser_if
// Description : Byte-in / packet-out handshake bundle of the receive parser.
// Revision    : 1.0 - initial release
// ============================================================================
interface vj_rx_parser_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] pkt_data_o;
  logic       pkt_valid_o;
  logic       pkt_last_o;
  logic       pkt_ready_i;
  logic       pkt_ok_o;
  logic       err_crc_o;
  logic       err_len_o;
  logic       err_timeout_o;

  modport slave (
    input  rx_data_i, rx_valid_i, pkt_ready_i,
    output rx_ready_o, pkt_data_o, pkt_valid_o, pkt_last_o,
    output pkt_ok_o, err_crc_o, err_len_o, err_timeout_o
  );

  modport master (
    output rx_data_i, rx_valid_i, pkt_ready_i,
    input  rx_ready_o, pkt_data_o, pkt_valid_o, pkt_last_o,
    input  pkt_ok_o, err_crc_o, err_len_o, err_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/vj_rx_buf.sv
`default_nettype none
// ============================================================================
// Module      : vj_rx_buf
// Description : MAX_LEN x 8 payload register file, write/read pointers,
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module vj_rx_buf #(
  parameter int MAX_LEN = 16,
  parameter int PTR_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_adv,
  output logic [7:0]       rd_data,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vj_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : vj_rx_parser
// Description : Frames the JTAG UART byte stream into checksummed packets and
//               releases each payload only after its checksum verifies.
// Revision    : 1.0 - initial release
// ============================================================================
module vj_rx_parser
  import vj_pkg::*;
#(
  parameter int         MAX_LEN     = VJ_MAX_LEN_DEFAULT,
  parameter logic [7:0] SOF         = VJ_SOF,
  parameter int         TIMEOUT_CYC = VJ_TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  vj_rx_parser_if.slave bus
);

  localparam int               PTR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  vj_state_e        state_q, state_d;
  logic             rx_ready_q;
  logic [7:0]       sum_q, sum_next;
  logic [PTR_W-1:0] len_m1_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic             ok_q, err_crc_q, err_len_q, err_to_q;
  logic             ok_d, err_crc_d, err_len_d, err_to_d;
  logic             accept, in_frame, drain, len_bad, timeout_hit;
  logic             rd_adv, buf_clr, buf_wr;
  logic [7:0]       rd_data;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign accept      = bus.rx_valid_i & rx_ready_q;
  assign in_frame    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign drain       = (state_q == ST_DRAIN);
  assign rd_adv      = drain & bus.pkt_ready_i;
  assign len_bad     = (bus.rx_data_i < VJ_LEN_MIN) || (int'(bus.rx_data_i) > MAX_LEN);
  assign timeout_hit = in_frame & ~accept & (idle_cnt_q == CNT_LAST);
  assign sum_next    = vj_csum_add(sum_q, bus.rx_data_i);

  vj_rx_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .clk     (clk_i),
    .rst_n   (nreset_i),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (bus.rx_data_i),
    .rd_adv  (rd_adv),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr)
  );

  always_comb begin
    state_d   = state_q;
    ok_d      = 1'b0;
    err_crc_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (bus.rx_data_i == SOF)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          if (len_bad) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            buf_clr = 1'b1;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          buf_wr = 1'b1;
          if (wr_ptr == len_m1_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (sum_next == VJ_CSUM_GOOD) begin
            ok_d    = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            err_crc_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_adv && (rd_ptr == len_m1_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Only reachable when no byte was accepted this cycle, so it never races a byte decision.
    if (timeout_hit) begin
      err_to_d = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      sum_q      <= '0;
      len_m1_q   <= '0;
      idle_cnt_q <= '0;
      ok_q       <= 1'b0;
      err_crc_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d != ST_DRAIN);
      ok_q       <= ok_d;
      err_crc_q  <= err_crc_d;
      err_len_q  <= err_len_d;
      err_to_q   <= err_to_d;
      if (accept && (state_q == ST_LEN)) begin
        sum_q    <= bus.rx_data_i;
        len_m1_q <= PTR_W'(bus.rx_data_i - 8'd1);
      end else if (accept && (state_q == ST_PAYLOAD)) begin
        sum_q <= sum_next;
      end
      if (accept || !in_frame || timeout_hit) idle_cnt_q <= '0;
      else                                    idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign bus.rx_ready_o    = rx_ready_q;
  assign bus.pkt_valid_o   = drain;
  assign bus.pkt_data_o    = drain ? rd_data : 8'h00;
  assign bus.pkt_last_o    = drain && (rd_ptr == len_m1_q);
  assign bus.pkt_ok_o      = ok_q;
  assign bus.err_crc_o     = err_crc_q;
  assign bus.err_len_o     = err_len_q;
  assign bus.err_timeout_o = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_vj_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_vj_rx_parser
// Description : Directed, table-driven bench for vj_rx_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vj_rx_parser;

  localparam int K_OK  = 0;
  localparam int K_CRC = 1;
  localparam int K_LEN = 2;
  localparam int NV    = 8;

  typedef struct {
    logic [191:0] frame;  // bytes MSB-first, n bytes long
    int           n;
    int           kind;
    int           off;    // index of first payload byte in frame
    int           npay;
  } vec_t;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;
  int n_ok = 0, n_crc = 0, n_len = 0, n_to = 0, n_vcyc = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;
  vec_t       vecs[NV];

  vj_rx_parser_if bus();

  vj_rx_parser #(
    .MAX_LEN     (16),
    .SOF         (8'h7E),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] byte_at(input logic [191:0] f, input int n, input int i);
    return f[8*(n-1-i) +: 8];
  endfunction

  // Observe downstream traffic and invariants away from the rising edge.
  always @(negedge clk) begin
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.pkt_ok_o)      n_ok++;
      if (bus.err_crc_o)     n_crc++;
      if (bus.err_len_o)     n_len++;
      if (bus.err_timeout_o) n_to++;
      if (bus.pkt_ok_o)
        check("ok_no_err", {29'd0, bus.err_crc_o, bus.err_len_o, bus.err_timeout_o}, 0);
      if (bus.pkt_valid_o) begin
        n_vcyc++;
        check("drain_rx_ready", bus.rx_ready_o, 0);
      end
      if (prev_stall) begin
        check("hold_valid", bus.pkt_valid_o, 1);
        check("hold_data", bus.pkt_data_o, prev_data);
        check("hold_last", bus.pkt_last_o, prev_last);
      end
      if (bus.pkt_valid_o && bus.pkt_ready_i) begin
        q_data.push_back(bus.pkt_data_o);
        q_last.push_back(bus.pkt_last_o);
      end
      prev_stall = bus.pkt_valid_o & ~bus.pkt_ready_i;
      prev_data  = bus.pkt_data_o;
      prev_last  = bus.pkt_last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (!bus.rx_ready_o && waited < 50) begin
      tick();
      waited++;
    end
    check("send_accept", bus.rx_ready_o, 1);
    tick();
  endtask

  task automatic send_frame(input logic [191:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(byte_at(f, n, i));
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic expect_payload(input string tag, input logic [191:0] f, input int n,
                                input int off, input int npay);
    check({tag, "_count"}, q_data.size(), npay);
    for (int i = 0; i < npay && i < q_data.size(); i++) begin
      check({tag, "_data"}, q_data[i], byte_at(f, n, off + i));
      check({tag, "_last"}, q_last[i], (i == npay - 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, bus.rx_ready_o, 0);
    check({tag, "_pkt_valid"}, bus.pkt_valid_o, 0);
    check({tag, "_pkt_data"}, bus.pkt_data_o, 0);
    check({tag, "_pkt_last"}, bus.pkt_last_o, 0);
    check({tag, "_pkt_ok"}, bus.pkt_ok_o, 0);
    check({tag, "_err_crc"}, bus.err_crc_o, 0);
    check({tag, "_err_len"}, bus.err_len_o, 0);
    check({tag, "_err_to"}, bus.err_timeout_o, 0);
  endtask

  initial begin
    int ok0, crc0, len0, to0, vc0;
    logic [191:0] bp_frame, rs_frame, good_frame;

    // 7E 03 11 22 33 97: 03+11+22+33 = 69, 69+97 wraps to 00.
    vecs[0] = '{frame: 192'h7E0311223397, n: 6, kind: K_OK, off: 2, npay: 3};
    vecs[1] = '{frame: 192'h7E0311223398, n: 6, kind: K_CRC, off: 2, npay: 0};
    vecs[2] = '{frame: 192'h7E0311223397, n: 6, kind: K_OK, off: 2, npay: 3};
    vecs[3] = '{frame: 192'h7E00, n: 2, kind: K_LEN, off: 2, npay: 0};
    vecs[4] = '{frame: 192'h7E11, n: 2, kind: K_LEN, off: 2, npay: 0};
    // LEN=10, payload 01..10 sums to 88; 10+88=98, CSUM=68.
    vecs[5] = '{frame: 192'h7E10_0102030405060708090A0B0C0D0E0F10_68, n: 19, kind: K_OK, off: 2, npay: 16};
    // Garbage 00 FF 7F ahead; 02+AA+55 = 101 -> 01, CSUM=FF.
    vecs[6] = '{frame: 192'h00FF7F_7E02AA55FF, n: 8, kind: K_OK, off: 5, npay: 2};
    // SOF values as payload data: 02+7E+7E = FE, CSUM=02.
    vecs[7] = '{frame: 192'h7E027E7E02, n: 5, kind: K_OK, off: 2, npay: 2};

    bus.rx_valid_i  = 1'b0;
    bus.rx_data_i   = 8'h00;
    bus.pkt_ready_i = 1'b1;
    nreset = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    nreset = 1'b1;
    tick();
    tick();
    check("post_reset_rx_ready", bus.rx_ready_o, 1);

    for (int v = 0; v < NV; v++) begin
      ok0 = n_ok; crc0 = n_crc; len0 = n_len; to0 = n_to; vc0 = n_vcyc;
      q_data.delete();
      q_last.delete();
      send_frame(vecs[v].frame, vecs[v].n);
      case (vecs[v].kind)
        K_OK: begin
          check("vec_ok_pulse", bus.pkt_ok_o, 1);
          check("vec_ok_valid", bus.pkt_valid_o, 1);
          check("vec_ok_byte0", bus.pkt_data_o, byte_at(vecs[v].frame, vecs[v].n, vecs[v].off));
          check("vec_ok_rx_ready", bus.rx_ready_o, 0);
        end
        K_CRC: begin
          check("vec_crc_pulse", bus.err_crc_o, 1);
          check("vec_crc_rx_ready", bus.rx_ready_o, 1);
          check("vec_crc_valid", bus.pkt_valid_o, 0);
        end
        default: begin
          check("vec_len_pulse", bus.err_len_o, 1);
          check("vec_len_rx_ready", bus.rx_ready_o, 1);
        end
      endcase
      repeat (vecs[v].npay + 3) tick();
      check("vec_ok_count", n_ok - ok0, (vecs[v].kind == K_OK) ? 1 : 0);
      check("vec_crc_count", n_crc - crc0, (vecs[v].kind == K_CRC) ? 1 : 0);
      check("vec_len_count", n_len - len0, (vecs[v].kind == K_LEN) ? 1 : 0);
      check("vec_to_count", n_to - to0, 0);
      check("vec_drain_cycles", n_vcyc - vc0, vecs[v].npay);
      check("vec_idle_rx_ready", bus.rx_ready_o, 1);
      expect_payload("vec_payload", vecs[v].frame, vecs[v].n, vecs[v].off, vecs[v].npay);
    end

    // Inter-byte timeout: 7E 02 11 then silence.
    to0 = n_to; vc0 = n_vcyc;
    send_frame(192'h7E0211, 3);
    repeat (999) tick();
    check("to_not_yet", bus.err_timeout_o, 0);
    tick();
    check("to_pulse", bus.err_timeout_o, 1);
    check("to_rx_ready", bus.rx_ready_o, 1);
    tick();
    check("to_pulse_end", bus.err_timeout_o, 0);
    check("to_count", n_to - to0, 1);
    check("to_no_valid", n_vcyc - vc0, 0);

    // Downstream backpressure, including a stall longer than the timeout.
    // 04+A1+B2+C3+D4 = 2EE -> EE, CSUM=12.
    bp_frame = 192'h7E04A1B2C3D412;
    ok0 = n_ok; to0 = n_to;
    q_data.delete();
    q_last.delete();
    bus.pkt_ready_i = 1'b0;
    send_frame(bp_frame, 7);
    check("bp_ok_pulse", bus.pkt_ok_o, 1);
    check("bp_byte0", bus.pkt_data_o, 8'hA1);
    repeat (1100) tick();
    check("bp_stall_valid", bus.pkt_valid_o, 1);
    check("bp_stall_data", bus.pkt_data_o, 8'hA1);
    check("bp_stall_no_to", n_to - to0, 0);
    for (int c = 0; c < 40 && q_data.size() < 4; c++) begin
      bus.pkt_ready_i = ~bus.pkt_ready_i;
      tick();
    end
    bus.pkt_ready_i = 1'b1;
    repeat (3) tick();
    check("bp_ok_count", n_ok - ok0, 1);
    check("bp_rx_ready", bus.rx_ready_o, 1);
    expect_payload("bp_payload", bp_frame, 7, 2, 4);

    // Reset after the second payload byte, then a fresh frame.
    rs_frame = 192'h7E04A1B2;
    vc0 = n_vcyc;
    q_data.delete();
    q_last.delete();
    send_frame(rs_frame, 4);
    nreset = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    nreset = 1'b1;
    tick();
    tick();
    check("midrst_rx_ready", bus.rx_ready_o, 1);
    check("midrst_no_emit", q_data.size(), 0);
    check("midrst_no_valid", n_vcyc - vc0, 0);
    good_frame = 192'h7E0311223397;
    ok0 = n_ok;
    send_frame(good_frame, 6);
    repeat (6) tick();
    check("midrst_ok_count", n_ok - ok0, 1);
    expect_payload("midrst_payload", good_frame, 6, 2, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vj_rx_parser.md
# vj_rx_parser

- Host-to-FPGA counterpart of the JTAG transmit FSM.
- Consumes the byte stream arriving from the virtual JTAG UART receive side and frames it into checksummed packets.
- Buffers each packet's payload and releases it downstream only after the checksum verifies.
- Instantiated beside the transmit FSM in the DE0 top level, on `sysclk`, with reset from the reset timer.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes (≥1).
- `SOF`, 8'h7E: start-of-frame byte.
- `TIMEOUT_CYC`, 1000: idle cycles inside a frame before abort (≥2).

Ports:
- `clk_i`, in, 1: system clock. The block uses one clock only.
- `nreset_i`, in, 1: reset, asynchronous, active-low.
- `rx_data_i`, in, 8: byte from the JTAG receive side.
- `rx_valid_i`, in, 1: `rx_data_i` is valid.
- `rx_ready_o`, out, 1: the block accepts a byte when `rx_valid_i & rx_ready_o`.
- `pkt_data_o`, out, 8: payload byte to downstream.
- `pkt_valid_o`, out, 1: `pkt_data_o` is valid.
- `pkt_last_o`, out, 1: the current byte is the final payload byte.
- `pkt_ready_i`, in, 1: downstream accepts the byte.
- `pkt_ok_o`, out, 1: one-cycle pulse when a frame verifies.
- `err_crc_o`, out, 1: one-cycle pulse on checksum failure.
- `err_len_o`, out, 1: one-cycle pulse on illegal length.
- `err_timeout_o`, out, 1: one-cycle pulse on inter-byte timeout.

## Operation
- Frame format: `SOF`, `LEN`, `LEN` payload bytes, `CSUM`.
  - A frame is valid iff (`LEN` + Σpayload + `CSUM`) mod 256 == 0.
  - The running sum is 8 bits and wraps.
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- IDLE: accept bytes, discard anything that is not `SOF`. On `SOF` → LEN.
- LEN: accept the byte.
  - `LEN`==0 or `LEN`>`MAX_LEN` → pulse `err_len_o`, → IDLE.
  - Otherwise store `LEN`, seed the sum with it, → PAYLOAD.
- PAYLOAD: each accepted byte is written to the buffer and added to the sum. After `LEN` bytes → CSUM.
  - `SOF` values inside the payload are plain data; there is no escaping.
- CSUM: accept the byte.
  - Sum OK → pulse `pkt_ok_o`, → DRAIN.
  - Sum bad → pulse `err_crc_o`, discard the buffer, → IDLE.
- DRAIN:
  - `rx_ready_o`=0.
  - `pkt_data_o` = buffer[rd_ptr].
  - `pkt_valid_o`=1.
  - `pkt_last_o`=1 when rd_ptr==`LEN`-1.
  - rd_ptr advances on `pkt_valid_o & pkt_ready_i`.
  - The handshake on the last byte → IDLE.
- Timeout:
  - In LEN, PAYLOAD and CSUM, a counter increments every cycle with no accepted byte and clears on each accepted byte.
  - On reaching `TIMEOUT_CYC` → pulse `err_timeout_o`, → IDLE.
  - The counter is inactive in IDLE and DRAIN. Downstream stall is never a timeout.
- Reset value of every output is 0, except `rx_ready_o`=1 once out of reset.
- Asserting `nreset_i` mid-frame or mid-drain clears state to IDLE, clears the pointers, sum and counter, and zeroes all outputs immediately. Partial data is never emitted.

## Timing
- `rx_ready_o` is a registered function of state: 1 in IDLE, LEN, PAYLOAD and CSUM.
- `rx_ready_o` does not depend on `rx_valid_i` combinationally.
- CSUM byte accepted at edge k:
  - Good frame: at cycle k+1, `pkt_ok_o`=1, `pkt_valid_o`=1, and byte 0 is presented.
  - Bad frame: at cycle k+1, `err_crc_o`=1 and `rx_ready_o`=1.
- `pkt_data_o` and `pkt_last_o` hold stable while `pkt_valid_o & !pkt_ready_i`.
- With `pkt_ready_i` held at 1, DRAIN lasts exactly `LEN` cycles.
- The last-byte handshake at edge m gives `rx_ready_o`=1 at cycle m+1.
- Error pulses are asserted in the cycle after the offending byte or timeout, for exactly one cycle.
- Error pulses never coincide with `pkt_ok_o`.
- Throughput: one input byte per cycle; frame overhead is 3 bytes plus drain time.

## Structure
- Shared package `vj_pkg` holds:
  - the state encoding (IDLE..DRAIN);
  - the default `SOF`;
  - the frame-format constants, which the transmit FSM also uses.
- Sub-module `vj_rx_buf` is a `MAX_LEN`×8 register file with a write pointer (clears at LEN), a read pointer and a combinational read port.
- The FSM, sum and timeout counter live in `vj_rx_parser`.
- Pointer and counter widths are `$clog2` of `MAX_LEN` and `TIMEOUT_CYC`.

## Test plan
- Good frame 7E 03 11 22 33 97, `pkt_ready_i`=1 → output 11, 22, 33 with `pkt_last_o` on 33, `pkt_ok_o` one pulse, then back to IDLE.
- Same frame with `CSUM`=98 → `err_crc_o` pulse, no `pkt_valid_o`. A following good frame is delivered intact.
- `LEN`=00, then `LEN`=11 (with `MAX_LEN`=16) → `err_len_o` pulse each time. A frame with `LEN`=10 and 16 bytes of payload is accepted.
- Garbage bytes 00 FF 7F ahead of a good frame → ignored, frame delivered. Bytes 7E 02 11 then a 1000-cycle stall → `err_timeout_o` pulse at the 1000th stall cycle.
- Good 4-byte frame with `pkt_ready_i` toggling 1/0 → bytes held stable, delivered in order, `rx_ready_o`=0 throughout DRAIN, no timeout.
- `nreset_i` asserted after the 2nd payload byte → all outputs 0 immediately. After release, a fresh good frame is delivered correctly.
